// File: rtl/arb_resp_router.sv
// Return-path router: records accepted grant indices in issue order and steers each in-order response to its requester.
// Optional sticky protocol-error flag `err` is enabled by defining ARB_RESP_ROUTER_ERR_EN.
module arb_resp_router #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           grant,
  input  logic                         req_fire,
  output logic                         req_stall,
  input  logic                         rsp_valid,
  input  logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_ready,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [DATA_W-1:0]            rsp_data_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
`ifdef ARB_RESP_ROUTER_ERR_EN
  ,
  output logic                         err
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [IW-1:0] fifo_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic [IW-1:0] idx_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          grant_nz_s;

  // Non-one-hot grants resolve to the lowest set bit.
  function automatic logic [IW-1:0] enc_lowest(input logic [NUM_REQ-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
      else      r = r;
    end
    return r;
  endfunction

  assign idx_s      = fifo_r[rd_ptr_r];
  assign empty_s    = (cnt_r == {CW{1'b0}});
  assign full_s     = (cnt_r == CW'(DEPTH));
  assign grant_nz_s = (grant != {NUM_REQ{1'b0}});
  assign pop_s      = rsp_valid & rsp_ready;
  // A pop at full frees the slot, so a simultaneous push is still accepted.
  assign push_s     = req_fire & grant_nz_s & (~full_s | pop_s);

  assign rsp_ready   = ~empty_s & rsp_ready_i[idx_s];
  assign rsp_data_o  = rsp_data;
  assign req_stall   = full_s;
  assign outstanding = cnt_r;

  // One-hot response valid toward the requester at the FIFO head.
  always_comb begin
    rsp_valid_o = {NUM_REQ{1'b0}};
    if (rsp_valid && !empty_s) rsp_valid_o[idx_s] = 1'b1;
    else                       rsp_valid_o = {NUM_REQ{1'b0}};
  end

  // FIFO storage and pointer/occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= enc_lowest(grant);
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef ARB_RESP_ROUTER_ERR_EN
  logic grant_onehot_s;
  logic err_event_s;

  assign grant_onehot_s = grant_nz_s &
                          ((grant & (grant - NUM_REQ'(1))) == {NUM_REQ{1'b0}});
  assign err_event_s    = (req_fire & ~grant_onehot_s) |
                          (req_fire & full_s & ~pop_s) |
                          (rsp_valid & empty_s);

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            err <= 1'b0;
    else if (err_event_s) err <= 1'b1;
    else                  err <= err;
  end
`endif

endmodule

// File: tb/tb_arb_resp_router.sv
// Directed bench for arb_resp_router: vector table plus hand sequences for full, wrap, error and reset cases.
module tb_arb_resp_router;

  logic        clk;
  logic        rstn;
  logic [3:0]  grant;
  logic        req_fire;
  logic        req_stall;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic [3:0]  rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic [3:0]  rsp_ready_i;
  logic [3:0]  outstanding;
`ifdef ARB_RESP_ROUTER_ERR_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;

  arb_resp_router #(.NUM_REQ(4), .DATA_W(32), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .grant(grant), .req_fire(req_fire), .req_stall(req_stall),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .outstanding(outstanding)
`ifdef ARB_RESP_ROUTER_ERR_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic        f;
    logic        v;
    logic [31:0] d;
    logic [3:0]  r;
    logic [3:0]  evo;
    logic        erdy;
    logic [3:0]  eout;
    logic        estall;
  } vec_t;

  vec_t vecs [13];
  logic [3:0] q [$];
  logic [3:0] g_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle #1 later.
  task automatic cyc(input logic [3:0] g, input logic f, input logic v,
                     input logic [31:0] d, input logic [3:0] r);
    @(negedge clk);
    grant = g; req_fire = f; rsp_valid = v; rsp_data = d; rsp_ready_i = r;
    #1;
  endtask

  initial begin
    //           g      f     v     d              r        evo    rdy   out    stall
    vecs[0]  = '{4'b0100, 1'b1, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 1'b1, 32'hA5A5_0001, 4'b1111, 4'b0100, 1'b1, 4'd1, 1'b0};
    vecs[2]  = '{4'b0000, 1'b0, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{4'b0001, 1'b1, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{4'b0010, 1'b1, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b1, 4'd1, 1'b0};
    vecs[5]  = '{4'b1000, 1'b1, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 1'b1, 32'h0000_0011, 4'b1111, 4'b0001, 1'b1, 4'd3, 1'b0};
    vecs[7]  = '{4'b0000, 1'b0, 1'b1, 32'h0000_0022, 4'b1101, 4'b0010, 1'b0, 4'd2, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 1'b1, 32'h0000_0022, 4'b1101, 4'b0010, 1'b0, 4'd2, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 1'b1, 32'h0000_0022, 4'b1101, 4'b0010, 1'b0, 4'd2, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 1'b1, 32'h0000_0022, 4'b1111, 4'b0010, 1'b1, 4'd2, 1'b0};
    vecs[11] = '{4'b0000, 1'b0, 1'b1, 32'h0000_0033, 4'b1111, 4'b1000, 1'b1, 4'd1, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b0, 4'd0, 1'b0};

    rstn = 1'b0; grant = 4'b0; req_fire = 1'b0; rsp_valid = 1'b1;
    rsp_data = 32'h1234_5678; rsp_ready_i = 4'b1111;
    #2;
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_stall", 64'(req_stall), 64'd0);
    chk("reset_rsp_ready", 64'(rsp_ready), 64'd0);
    chk("reset_rsp_valid_o", 64'(rsp_valid_o), 64'd0);
    chk("reset_data_passthru", 64'(rsp_data_o), 64'h1234_5678);
`ifdef ARB_RESP_ROUTER_ERR_EN
    chk("reset_err", 64'(err), 64'd0);
`endif
    rsp_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // Round trip and in-order routing with backpressure.
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].g, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d_rsp_valid_o", i), 64'(rsp_valid_o), 64'(vecs[i].evo));
      chk($sformatf("vec%0d_rsp_ready", i), 64'(rsp_ready), 64'(vecs[i].erdy));
      chk($sformatf("vec%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].eout));
      chk($sformatf("vec%0d_stall", i), 64'(req_stall), 64'(vecs[i].estall));
      chk($sformatf("vec%0d_data", i), 64'(rsp_data_o), 64'(vecs[i].d));
    end

    // Empty response is refused.
    cyc(4'b0000, 1'b0, 1'b1, 32'hDEAD_0000, 4'b1111);
    chk("empty_rsp_ready", 64'(rsp_ready), 64'd0);
    chk("empty_rsp_valid_o", 64'(rsp_valid_o), 64'd0);
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("empty_outstanding", 64'(outstanding), 64'd0);
`ifdef ARB_RESP_ROUTER_ERR_EN
    chk("empty_err", 64'(err), 64'd1);
`endif

    // Zero grant dropped; multi-bit grant routes to its lowest bit.
    cyc(4'b0000, 1'b1, 1'b0, 32'h0, 4'b1111);
    cyc(4'b0110, 1'b1, 1'b0, 32'h0, 4'b1111);
    chk("zero_grant_dropped", 64'(outstanding), 64'd0);
    cyc(4'b0000, 1'b0, 1'b1, 32'h0000_0044, 4'b1111);
    chk("multibit_grant_route", 64'(rsp_valid_o), 64'b0010);
    chk("multibit_grant_ready", 64'(rsp_ready), 64'd1);
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("multibit_drained", 64'(outstanding), 64'd0);

    // Fill to DEPTH, drop a 9th, then fire+pop at full.
    q.delete();
    for (int i = 0; i < 8; i++) begin
      g_s = 4'b0001 << (i % 4);
      cyc(g_s, 1'b1, 1'b0, 32'h0, 4'b1111);
      q.push_back(g_s);
      if (i == 7) begin
        chk("fill_pre_stall", 64'(req_stall), 64'd0);
        chk("fill_pre_out", 64'(outstanding), 64'd7);
      end
    end
    cyc(4'b0100, 1'b1, 1'b0, 32'h0, 4'b1111);
    chk("full_stall", 64'(req_stall), 64'd1);
    chk("full_out", 64'(outstanding), 64'd8);
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("ninth_dropped", 64'(outstanding), 64'd8);
`ifdef ARB_RESP_ROUTER_ERR_EN
    chk("ninth_err", 64'(err), 64'd1);
`endif
    cyc(4'b1000, 1'b1, 1'b1, 32'h0000_0055, 4'b1111);
    chk("full_swap_route", 64'(rsp_valid_o), 64'(q[0]));
    chk("full_swap_ready", 64'(rsp_ready), 64'd1);
    void'(q.pop_front());
    q.push_back(4'b1000);
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("full_swap_out", 64'(outstanding), 64'd8);
    chk("full_swap_stall", 64'(req_stall), 64'd1);
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0000, 1'b0, 1'b1, 32'(k), 4'b1111);
      chk($sformatf("drain%0d_route", k), 64'(rsp_valid_o), 64'(q[0]));
      chk($sformatf("drain%0d_out", k), 64'(outstanding), 64'(8 - k));
      void'(q.pop_front());
    end
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("drain_empty", 64'(outstanding), 64'd0);
    chk("drain_stall", 64'(req_stall), 64'd0);

    // Steady occupancy 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      g_s = 4'b0001 << ((i * 3 + 1) % 4);
      cyc(g_s, 1'b1, 1'b0, 32'h0, 4'b1111);
      q.push_back(g_s);
    end
    for (int j = 0; j < 20; j++) begin
      g_s = 4'b0001 << ((j * 3 + 2) % 4);
      cyc(g_s, 1'b1, 1'b1, 32'(j), 4'b1111);
      chk($sformatf("wrap%0d_route", j), 64'(rsp_valid_o), 64'(q[0]));
      chk($sformatf("wrap%0d_out", j), 64'(outstanding), 64'd3);
      void'(q.pop_front());
      q.push_back(g_s);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0000, 1'b0, 1'b1, 32'h0, 4'b1111);
      chk($sformatf("wrapdrain%0d_route", k), 64'(rsp_valid_o), 64'(q[0]));
      void'(q.pop_front());
    end

    // Reset with five entries in flight.
    for (int i = 0; i < 5; i++) cyc(4'b0010, 1'b1, 1'b0, 32'h0, 4'b1111);
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("prereset_out", 64'(outstanding), 64'd5);
    @(negedge clk);
    rstn = 1'b0; rsp_valid = 1'b1;
    #1;
    chk("midreset_out", 64'(outstanding), 64'd0);
    chk("midreset_stall", 64'(req_stall), 64'd0);
    chk("midreset_rsp_valid_o", 64'(rsp_valid_o), 64'd0);
`ifdef ARB_RESP_ROUTER_ERR_EN
    chk("midreset_err", 64'(err), 64'd0);
`endif
    rsp_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    cyc(4'b0000, 1'b0, 1'b0, 32'h0, 4'b1111);
    chk("postreset_out", 64'(outstanding), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_resp_router.md
# arb_resp_router

Return-path companion to the round-robin request arbiter. It records the one-hot grant of every request the downstream target accepts, in issue order, and routes each downstream response back to the requester that issued the matching request. It sits between the arbitrated request port and the shared response channel, and enforces a bound on outstanding transactions.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; must be ≥ 2.
- DATA_W, 32, response data width.
- DEPTH, 8, maximum outstanding requests; power of 2, ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- grant  input  NUM_REQ  one-hot grant from the arbiter.
- req_fire  input  1  the downstream accepted the granted request this cycle.
- req_stall  output  1  outstanding tracker full; the upstream must not fire.
- rsp_valid  input  1  downstream response valid.
- rsp_data  input  DATA_W  downstream response payload.
- rsp_ready  output  1  router accepts the downstream response.
- rsp_valid_o  output  NUM_REQ  per-requester response valid; at most one bit set.
- rsp_data_o  output  DATA_W  response payload, broadcast to all requesters.
- rsp_ready_i  input  NUM_REQ  per-requester response ready.
- outstanding  output  $clog2(DEPTH+1)  number of in-flight requests.
- err  output  1  sticky protocol-error flag. Present only with ARB_RESP_ROUTER_ERR_EN.

## Operation
- Internal FIFO of DEPTH entries. Each entry holds the binary index ($clog2(NUM_REQ) bits) of one granted requester. The FIFO has read and write pointers that wrap modulo DEPTH, plus an occupancy counter `cnt` of width $clog2(DEPTH+1).
- **Push:** when req_fire=1, grant≠0 and cnt<DEPTH, write the encoded grant index at the write pointer. If grant is not one-hot, encode the lowest set bit.
- **Head:** idx = FIFO[rd_ptr]. empty = (cnt==0).
- **Routing (combinational):**
  - rsp_valid_o = (rsp_valid & ~empty) ? (1<<idx) : 0
  - rsp_ready = ~empty & rsp_ready_i[idx]
  - rsp_data_o = rsp_data
- **Pop:** occurs when rsp_valid & rsp_ready.
- **Counter update:**
  - Push only: cnt+1.
  - Pop only: cnt−1.
  - Push and pop in the same cycle: cnt unchanged and both pointers advance. This is legal at any occupancy, including cnt==DEPTH where the pop frees the slot, so the push is accepted.
- req_stall = (cnt==DEPTH), derived from the register with no input dependency.
- outstanding = cnt.
- **Ignored events:**
  - A push with cnt==DEPTH and no simultaneous pop is dropped.
  - req_fire with grant==0 is dropped.
  - A response arriving while empty is not accepted; rsp_ready stays 0.
- Ordering rule: responses are returned strictly in request-acceptance order. The downstream is required to respond in order.

## Timing
- **Reset values:** pointers=0, cnt=0, req_stall=0, outstanding=0, rsp_ready=0, rsp_valid_o=0, err=0. rsp_data_o follows rsp_data.
- Response path latency is zero cycles, combinational from rsp_valid, rsp_data and rsp_ready_i.
- A push becomes visible at the head on the cycle after req_fire. A request fired at cycle t can therefore have its response accepted at cycle t+1 at the earliest.
- req_stall asserts the cycle after the push that makes cnt reach DEPTH. It deasserts the cycle after the pop that brings cnt below DEPTH.
- Reset asserted mid-operation discards all outstanding entries immediately (asynchronous). Responses still pending downstream are then orphans; the system must drain or reset the downstream alongside this block.

## Configuration
- **ARB_RESP_ROUTER_ERR_EN defined:** port err exists. It is set on the next edge after any of the following events and is cleared only by reset:
  - req_fire with a non-one-hot grant (zero, or more than one bit set);
  - req_fire at cnt==DEPTH without a simultaneous pop;
  - rsp_valid while empty.
- **Not defined:** the err port and its logic are absent. The three events above are silently dropped, as described in Operation.

## Test plan
- **Single round trip.** NUM_REQ=4. Fire grant=4'b0100, then rsp_valid=1 with rsp_data=32'hA5A5_0001 and rsp_ready_i=4'b1111 on the next cycle. Required: rsp_valid_o=4'b0100, rsp_ready=1, outstanding goes 1→0.
- **Ordering with backpressure.** Fire grants 0001, 0010, 1000 back-to-back, then present three responses with rsp_ready_i[1]=0 for 3 cycles. Required: responses route to 0001, 0010, 1000 in that order; rsp_ready=0 while requester 1 stalls, and the response is held.
- **Full boundary.** DEPTH=8. Fire 8 requests with no responses. Required: req_stall=1 from the cycle after the 8th fire and outstanding=8. A 9th fire is dropped (err=1 with the macro). Then a simultaneous fire+pop at full leaves outstanding=8 with FIFO order intact.
- **Pointer wrap-around.** Run 20 request/response pairs at steady occupancy 3. Required: every response reaches the correct requester across the pointer wrap.
- **Empty response.** With outstanding=0, drive rsp_valid=1. Required: rsp_ready=0 and rsp_valid_o=0; err=1 on the next cycle with the macro.
- **Reset mid-operation.** With outstanding=5, pulse rstn low. Required: outstanding=0, req_stall=0 and rsp_valid_o=0 immediately, and err=0.
